// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads weight rows,
// skews activation vectors into the array, deskews column sums back into
// aligned result vectors and signals job completion.

// Fixed-depth register delay line (D >= 1), one instance per skewed lane.
module sac_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [D-1:0][W-1:0] sr;

    // Shift the lane value one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[D-1];

endmodule

module systolic_array_ctrl #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    parameter int A_W  = 4,
    parameter int W_W  = 8,
    parameter int S_W  = 32,
    parameter int N_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                load_w,
    input  logic [N_W-1:0]      n_vec,
    output logic                busy,
    output logic                done,
    input  logic [COLS*W_W-1:0] w_data,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [ROWS*A_W-1:0] act_data,
    input  logic                act_valid,
    output logic                act_ready,
    output logic [COLS*S_W-1:0] res_data,
    output logic                res_valid,
    output logic                arr_load_weight_en,
    output logic [ROWS*A_W-1:0] arr_row_in_flat,
    output logic [COLS*W_W-1:0] arr_col_in_flat,
    input  logic [COLS*S_W-1:0] arr_col_out_flat
);

    // Result tag travels ROWS+COLS registers: skew/array/deskew plus output reg.
    localparam int STAGES = ROWS + COLS - 1;
    localparam int RC_W   = $clog2(ROWS) + 1;
    localparam int DC_W   = $clog2(ROWS + COLS) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, FIN} state_t;

    state_t                    state, state_nxt;
    logic [N_W-1:0]            n_vec_q;
    logic [N_W-1:0]            vec_cnt;
    logic [RC_W-1:0]           row_cnt;
    logic [DC_W-1:0]           drn_cnt;
    logic                      act_hs;

    logic [ROWS-1:0][A_W-1:0]  act_vec;
    logic [ROWS-1:0][A_W-1:0]  act_gated;
    logic [ROWS-1:0][A_W-1:0]  row_skew;
    logic [COLS-1:0][S_W-1:0]  col_out;
    logic [COLS-1:0][S_W-1:0]  col_dsk;
    logic [COLS-1:0][S_W-1:0]  res_q;
    logic [STAGES:0]           vld_pipe;

    // Non-handshake cycles inject an all-zero bubble.
    assign act_vec         = act_data;
    assign act_gated       = act_hs ? act_vec : '0;
    assign arr_row_in_flat = row_skew;
    assign col_out         = arr_col_out_flat;
    assign res_data        = res_q;
    assign res_valid       = vld_pipe[STAGES];

    // Row i is delayed i cycles so partial sums meet it on the diagonal.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        if (i == 0) begin : g_pass
            assign row_skew[i] = act_gated[i];
        end else begin : g_dly
            sac_delay #(.W(A_W), .D(i)) u_dly (
                .clk (clk),
                .rst (rst),
                .d   (act_gated[i]),
                .q   (row_skew[i])
            );
        end
    end

    // Column j leaves the array j cycles late; pad it to line up with the last column.
    for (genvar j = 0; j < COLS; j++) begin : g_dskw
        if (j == COLS - 1) begin : g_pass
            assign col_dsk[j] = col_out[j];
        end else begin : g_dly
            sac_delay #(.W(S_W), .D(COLS - 1 - j)) u_dly (
                .clk (clk),
                .rst (rst),
                .d   (col_out[j]),
                .q   (col_dsk[j])
            );
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake/array-side outputs.
    always_comb begin
        state_nxt          = state;
        busy               = 1'b0;
        done               = 1'b0;
        w_ready            = 1'b0;
        act_ready          = 1'b0;
        act_hs             = 1'b0;
        arr_load_weight_en = 1'b0;
        arr_col_in_flat    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = load_w ? LOAD_W : COMPUTE;
            end
            LOAD_W: begin
                busy               = 1'b1;
                w_ready            = 1'b1;
                arr_load_weight_en = w_valid;
                if (w_valid) begin
                    arr_col_in_flat = w_data;
                    if (row_cnt == RC_W'(ROWS - 1))
                        state_nxt = (n_vec_q == '0) ? FIN : COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                // Ready drops when no vectors remain, so a zero-length job takes none.
                act_ready = (vec_cnt != n_vec_q);
                act_hs    = act_valid & act_ready;
                if (n_vec_q == '0)
                    state_nxt = FIN;
                else if (act_hs && vec_cnt == n_vec_q - N_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drn_cnt == DC_W'(STAGES)) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job parameters and per-phase counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_vec_q <= '0;
            vec_cnt <= '0;
            row_cnt <= '0;
            drn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) n_vec_q <= n_vec;
                    vec_cnt <= '0;
                    row_cnt <= '0;
                    drn_cnt <= '0;
                end
                LOAD_W:  if (w_valid) row_cnt <= row_cnt + RC_W'(1);
                COMPUTE: if (act_hs)  vec_cnt <= vec_cnt + N_W'(1);
                DRAIN:   drn_cnt <= drn_cnt + DC_W'(1);
                default: ;
            endcase
        end
    end

    // Valid-tag pipeline and registered result vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            res_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], act_hs};
            res_q    <= col_dsk;
        end
    end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for the 32x32 weight-stationary systolic array. It handles weight loading, skewed activation injection, deskewing of column results, and job completion.
- It sits between the activation/weight buffers and the array instance. It drives the array's load_weight_en, row_in_flat and col_in_flat, and consumes col_out_flat.
- Each job loads weights (optional), streams N activation vectors, drains the array, then pulses done.

Parameters:
- ROWS, 32, array rows (activation lanes).
- COLS, 32, array columns (output lanes).
- A_W, 4, activation width (unsigned).
- W_W, 8, weight width (unsigned).
- S_W, 32, partial-sum width.
- N_W, 16, width of the vector-count field.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job launch pulse; ignored while busy=1.
- load_w  in  1  sampled with start; 1 = load a new weight set first, 0 = reuse resident weights.
- n_vec  in  N_W  sampled with start; number of activation vectors in the job.
- busy  out  1  high from the accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse at job end.
- w_data  in  COLS*W_W  one weight row (column j at bits [W_W*j +: W_W]).
- w_valid  in  1  weight row valid.
- w_ready  out  1  weight row accepted when w_valid & w_ready.
- act_data  in  ROWS*A_W  one activation vector (row i at bits [A_W*i +: A_W]).
- act_valid  in  1  activation vector valid.
- act_ready  out  1  activation vector accepted when act_valid & act_ready.
- res_data  out  COLS*S_W  deskewed result vector (column j at bits [S_W*j +: S_W]).
- res_valid  out  1  result valid; no backpressure, the consumer must sink every cycle.
- arr_load_weight_en  out  1  to array load_weight_en.
- arr_row_in_flat  out  ROWS*A_W  to array row_in_flat.
- arr_col_in_flat  out  COLS*W_W  to array col_in_flat.
- arr_col_out_flat  in  COLS*S_W  from array col_out_flat.

Behaviour:
- Reset values: busy, done, w_ready, act_ready, res_valid and arr_load_weight_en are 0. arr_row_in_flat, arr_col_in_flat and res_data are 0. FSM is in IDLE. All skew/deskew/valid pipelines are cleared.
- Reset asserted mid-job aborts immediately. There is no done pulse, and the array contents are don't-care until the next load_w=1 job.
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, FIN.
- IDLE:
  - start=1 latches load_w and n_vec and sets busy.
  - Next state is LOAD_W if load_w=1, else COMPUTE.
- LOAD_W:
  - w_ready=1 and arr_load_weight_en = w_valid; arr_col_in_flat = w_data when w_valid, else 0.
  - Row counter increments per handshake. After the ROWS-th handshake, go to COMPUTE (or FIN if n_vec=0).
  - Rows are supplied bottom-first: the first accepted row lands in array row ROWS-1.
  - w_valid gaps do not shift the array.
  - arr_row_in_flat stays 0 throughout.
- COMPUTE:
  - act_ready=1 and arr_load_weight_en=0; arr_col_in_flat=0.
  - The vector counter increments per handshake. After the n_vec-th handshake, go to DRAIN.
  - A cycle without a handshake injects an all-zero bubble with valid tag 0.
- Activation skew:
  - Row i passes through an i-stage delay line (row 0 has no delay) before arr_row_in_flat.
  - A per-vector valid tag travels alongside with delay ROWS-1+COLS.
- Array timing: each PE registers out_a and out_sum with 1-cycle latency. Column j of the vector injected at cycle T appears on arr_col_out_flat at T+ROWS+j.
- Output deskew and latency:
  - Column j passes through a (COLS-1-j)-stage delay, then one output register.
  - A vector accepted at cycle T gives res_valid=1 and res_data at cycle T+ROWS+COLS, which is 64 for the default sizes.
  - Results appear in acceptance order; bubbles never raise res_valid.
- DRAIN:
  - act_ready=0 and zeros are injected.
  - Leave when the last accepted vector's res_valid has been emitted, i.e. ROWS+COLS cycles after the last handshake. Go to FIN.
- FIN: done=1 and busy=0 for one cycle, then return to IDLE. A start in the FIN cycle is ignored.
- n_vec=0:
  - With load_w=1, the job loads weights then goes to FIN.
  - With load_w=0, it goes IDLE→COMPUTE→FIN with no handshakes.
  - No res_valid is produced in either case.
- Arithmetic: the array zero-extends activations and weights. The maximum column sum is 32*15*255 = 122400, so S_W=32 never overflows.
- w_ready=0 outside LOAD_W; act_ready=0 outside COMPUTE.

Test Plan:
- Weight load ordering: load_w=1 with rows r=31..0 each filled with value r+1, then one vector of all 1s. Every res_data column must equal 528, exactly 64 cycles after the act handshake.
- Streaming with no gaps: n_vec=4, vectors of all 1s, all 2s, all 3s and all 15s on back-to-back cycles. Four consecutive res_valid cycles must give column values 528, 1056, 1584 and 7920, then done.
- Bubbles: n_vec=3 with act_valid low for 2 cycles between vectors. res_valid must show the same 2-cycle gap, and the values must match the no-bubble case.
- Weight reuse and zero-length jobs:
  - load_w=0 after the previous job must reproduce the earlier results.
  - n_vec=0 with load_w=0 must pulse done 2 cycles after start, with no res_valid.
- Handshake stalls: w_valid toggling during LOAD_W must shift arr_load_weight_en only on valid cycles. Column sums must still be 528.
- Reset mid-COMPUTE: assert rst after 2 of 4 vectors. All outputs must be 0 and no done may pulse. A full new load_w=1 job afterwards must produce correct results.
